// File: rtl/core_pkg.sv
// core_pkg: shared register-file geometry and writeback source indices
package core_pkg;
  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int AW = $clog2(NREG);
  localparam logic [AW-1:0] REG_X0 = '0;
  localparam int SRC_EX = 0;
  localparam int SRC_LSU = 1;
endpackage

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter, pointer flips away from the winner under contention
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  logic ptr_q, ptr_d;
  // grant the lone requester, else the pointed-to source, and hand priority to the loser
  always_comb begin
    gnt = (&req) ? (ptr_q ? 2'b10 : 2'b01) : req;
    ptr_d = (&req) ? ~ptr_q : ptr_q;
  end
  // priority pointer register
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= 1'b0;
    else ptr_q <= ptr_d;
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: register-file write port owner with writeback arbitration and busy scoreboard
module regfile_wb_arbiter
  import core_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic [AW-1:0]     issue_rd,
  input  logic              issue_rd_we,
  input  logic [AW-1:0]     issue_rs1,
  input  logic [AW-1:0]     issue_rs2,
  output logic              issue_stall,
  input  logic [1:0]        wb_valid,
  output logic [1:0]        wb_ready,
  input  logic [2*AW-1:0]   wb_rd,
  input  logic [2*XLEN-1:0] wb_data,
  output logic              rf_we,
  output logic [AW-1:0]     rf_rd_addr,
  output logic [XLEN-1:0]   rf_rd_data,
  output logic [NREG-1:0]   busy
);
  logic [1:0] req;
  logic xfer, win;
  logic [AW-1:0] sel_rd;
  logic [XLEN-1:0] sel_data;
  logic rf_we_q, rf_we_d;
  logic [AW-1:0] rf_rd_addr_q, rf_rd_addr_d;
  logic [XLEN-1:0] rf_rd_data_q, rf_rd_data_d;
  logic [NREG-1:0] busy_q, busy_d;
  assign req = rst ? 2'b00 : wb_valid;
  rr_arb2 u_arb (.clk(clk), .rst(rst), .req(req), .gnt(wb_ready));
  // pick the winner's payload and form the next output-stage contents
  always_comb begin
    xfer = |wb_ready;
    win = wb_ready[SRC_LSU];
    sel_rd = win ? wb_rd[SRC_LSU*AW +: AW] : wb_rd[SRC_EX*AW +: AW];
    sel_data = win ? wb_data[SRC_LSU*XLEN +: XLEN] : wb_data[SRC_EX*XLEN +: XLEN];
    rf_we_d = xfer & (sel_rd != REG_X0);
    rf_rd_addr_d = xfer ? sel_rd : rf_rd_addr_q;
    rf_rd_data_d = xfer ? sel_data : rf_rd_data_q;
  end
  // scoreboard: commit clears, issue sets afterwards so a same-index set wins; x0 never busy
  always_comb begin
    busy_d = busy_q;
    if (rf_we_q) busy_d[rf_rd_addr_q] = 1'b0;
    if (issue_valid & ~issue_stall & issue_rd_we & (issue_rd != REG_X0)) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end
  // hazard check against registered busy only, no commit bypass
  always_comb begin
    issue_stall = issue_valid & (busy_q[issue_rs1] | busy_q[issue_rs2] | (issue_rd_we & busy_q[issue_rd]));
  end
  // output stage and scoreboard registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we_q <= 1'b0;
      rf_rd_addr_q <= '0;
      rf_rd_data_q <= '0;
      busy_q <= '0;
    end else begin
      rf_we_q <= rf_we_d;
      rf_rd_addr_q <= rf_rd_addr_d;
      rf_rd_data_q <= rf_rd_data_d;
      busy_q <= busy_d;
    end
  end
  assign rf_we = rf_we_q & ~rst;
  assign rf_rd_addr = rf_rd_addr_q;
  assign rf_rd_data = rf_rd_data_q;
  assign busy = busy_q;
endmodule
